// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the IF->ID boundary: bus widths, exception codes
// and the stage occupancy encoding.
package if_id_stage_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int EXC_W_DEF  = 4;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [3:0] EXC_NONE = 4'h0;
  localparam logic [3:0] EXC_ADEL = 4'h4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b10
  } stage_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, intended for performance
// counters that must never wrap.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_r;

  // Count register: holds at all-ones once reached.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc && (cnt_r != MAX)) begin
      cnt_r <= cnt_r + ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/if_id_stage.sv
// IF->ID pipeline register with valid/ready handshake, a skid entry so that
// if_ready is flop-driven, synchronous flush and a saturating stall counter.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int EXC_W  = EXC_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [DATA_W-1:0] if_inst,
  input  logic [EXC_W-1:0]  if_exc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_inst,
  output logic [EXC_W-1:0]  id_exc,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int ENT_W = ADDR_W + DATA_W + EXC_W;

  stage_state_e     state_r, state_nxt_s;
  logic [ENT_W-1:0] main_r, main_nxt_s;
  logic [ENT_W-1:0] skid_r, skid_nxt_s;
  logic [ENT_W-1:0] in_ent_s;
  logic             id_valid_r, if_ready_r;
  logic             in_fire_s, out_fire_s;

  assign in_ent_s   = {if_pc, if_inst, if_exc};
  assign in_fire_s  = if_valid & if_ready_r;
  assign out_fire_s = id_valid_r & id_ready;

  // Next occupancy and payload; main is zeroed whenever it goes empty so ID sees a NOP.
  always_comb begin
    state_nxt_s = state_r;
    main_nxt_s  = main_r;
    skid_nxt_s  = skid_r;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
      main_nxt_s  = {ENT_W{1'b0}};
      skid_nxt_s  = {ENT_W{1'b0}};
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) begin
            state_nxt_s = ST_FULL;
            main_nxt_s  = in_ent_s;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (in_fire_s && out_fire_s) begin
            main_nxt_s = in_ent_s;
          end else if (in_fire_s) begin
            state_nxt_s = ST_SKID;
            skid_nxt_s  = in_ent_s;
          end else if (out_fire_s) begin
            state_nxt_s = ST_EMPTY;
            main_nxt_s  = {ENT_W{1'b0}};
          end else begin
            state_nxt_s = ST_FULL;
          end
        end
        ST_SKID: begin
          if (out_fire_s) begin
            state_nxt_s = ST_FULL;
            main_nxt_s  = skid_r;
            skid_nxt_s  = {ENT_W{1'b0}};
          end else begin
            state_nxt_s = ST_SKID;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
          main_nxt_s  = {ENT_W{1'b0}};
          skid_nxt_s  = {ENT_W{1'b0}};
        end
      endcase
    end
  end

  // Registers; handshake outputs are decoded from the next state so both stay flop-driven.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_EMPTY;
      main_r     <= {ENT_W{1'b0}};
      skid_r     <= {ENT_W{1'b0}};
      id_valid_r <= 1'b0;
      if_ready_r <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      main_r     <= main_nxt_s;
      skid_r     <= skid_nxt_s;
      id_valid_r <= (state_nxt_s != ST_EMPTY);
      if_ready_r <= (state_nxt_s != ST_SKID);
    end
  end

  assign if_ready = if_ready_r;
  assign id_valid = id_valid_r;
  assign {id_pc, id_inst, id_exc} = main_r;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (id_valid_r & ~id_ready),
    .clr (1'b0),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the stage's occupancy.
module tb_if_id_stage;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int EW = 4;
  localparam int CW = 3;
  localparam int CNT_MAX = 7;

  logic          clk = 1'b0;
  logic          rst, flush, if_valid, if_ready, id_valid, id_ready;
  logic [AW-1:0] if_pc, id_pc;
  logic [DW-1:0] if_inst, id_inst;
  logic [EW-1:0] if_exc, id_exc;
  logic [CW-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] inst;
    logic [EW-1:0] exc;
  } ent_t;

  ent_t q[$];
  int   m_cnt = 0;

  always #5 clk = ~clk;

  if_id_stage #(.ADDR_W(AW), .DATA_W(DW), .EXC_W(EW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_inst(if_inst), .if_exc(if_exc),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_inst(id_inst), .id_exc(id_exc),
    .stall_cnt(stall_cnt)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after it.
  task automatic cyc(input logic r, input logic fl, input logic v,
                     input logic [AW-1:0] pc, input logic [DW-1:0] inst,
                     input logic [EW-1:0] exc, input logic rdy);
    bit   in_f, out_f;
    ent_t head;
    ent_t ent;
    rst = r; flush = fl; if_valid = v;
    if_pc = pc; if_inst = inst; if_exc = exc; id_ready = rdy;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_cnt = 0;
    end else begin
      in_f  = v && (q.size() < 2);
      out_f = (q.size() > 0) && rdy;
      if ((q.size() > 0) && !rdy && (m_cnt < CNT_MAX)) m_cnt++;
      if (out_f) void'(q.pop_front());
      ent.pc = pc; ent.inst = inst; ent.exc = exc;
      if (fl) q.delete();
      else if (in_f) q.push_back(ent);
    end
    #1;
    head = (q.size() > 0) ? q[0] : '0;
    check_val("id_valid",  64'(id_valid),  64'(q.size() > 0));
    check_val("if_ready",  64'(if_ready),  64'(q.size() < 2));
    check_val("id_pc",     64'(id_pc),     64'(head.pc));
    check_val("id_inst",   64'(id_inst),   64'(head.inst));
    check_val("id_exc",    64'(id_exc),    64'(head.exc));
    check_val("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rdy);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
    if_pc = '0; if_inst = '0; if_exc = '0;

    // Reset then a streaming burst
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'b0, 1'b1, 32'hBFC0_0000 + 32'(4 * i), 32'h2401_0001 + 32'(i), 4'h0, 1'b1);
    idle(1'b1);

    // Backpressure into the skid entry, then drain
    cyc(1'b0, 1'b0, 1'b1, 32'h100, 32'hAAAA_0100, 4'h0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'h104, 32'hAAAA_0104, 4'h0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'h108, 32'hAAAA_0108, 4'h0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'h10C, 32'hAAAA_010C, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Flush in SKID while IF offers 0x200
    cyc(1'b0, 1'b0, 1'b1, 32'h100, 32'hBBBB_0100, 4'h0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'h104, 32'hBBBB_0104, 4'h0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 32'h200, 32'hBBBB_0200, 4'h0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Exception code pass-through
    cyc(1'b0, 1'b0, 1'b1, 32'h3, 32'hCCCC_0003, 4'h4, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 32'h8, 32'hCCCC_0008, 4'h0, 1'b1);
    idle(1'b1);

    // Counter saturation, survives flush, cleared by reset
    cyc(1'b0, 1'b0, 1'b1, 32'h400, 32'hDDDD_0400, 4'h0, 1'b0);
    for (int i = 0; i < 10; i++) idle(1'b0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    idle(1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

    // Reset while in SKID
    cyc(1'b0, 1'b0, 1'b1, 32'h500, 32'hEEEE_0500, 4'h0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'h504, 32'hEEEE_0504, 4'h0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 32'h508, 32'hEEEE_0508, 4'h0, 1'b0);
    idle(1'b1);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 150) == 0, ($urandom % 25) == 0, ($urandom % 4) != 0,
          32'($urandom), 32'($urandom), 4'($urandom % 6), ($urandom % 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
Parametrised IF->ID pipeline boundary register, successor to the plain IF/ID latch. Adds valid/ready handshaking, a 2-entry skid buffer so the ready path to IF is registered, synchronous flush for branch and exception redirect, and a saturating stall counter. Sits between the fetch unit (PC and instruction memory) and the decoder.

Parameters:
ADDR_W, 32, width of PC fields
DATA_W, 32, width of instruction fields
EXC_W, 4, width of the fetch exception code carried with the instruction (0 = none)
CNT_W, 16, width of the stall performance counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
flush  in  1  discard all held entries this cycle
if_valid  in  1  IF offers an entry
if_ready  out  1  stage can accept; equals !skid_full (flop-driven)
if_pc  in  ADDR_W  fetched PC
if_inst  in  DATA_W  fetched instruction
if_exc  in  EXC_W  fetch exception code
id_valid  out  1  entry presented to ID
id_ready  in  1  ID consumes the entry
id_pc  out  ADDR_W  PC to ID
id_inst  out  DATA_W  instruction to ID
id_exc  out  EXC_W  exception code to ID
stall_cnt  out  CNT_W  cycles with id_valid=1 and id_ready=0, saturating

Behaviour:
- Reset (rst=1 at posedge): state EMPTY; id_valid=0; id_pc, id_inst, id_exc=0; skid cleared; stall_cnt=0; if_ready=1 from the first cycle after reset.
- Transfer rules: in_fire = if_valid & if_ready; out_fire = id_valid & id_ready. Output fields come straight from the main register (zero combinational path from if_* to id_*). Latency is 1 cycle from in_fire to id_valid.
- States:
  EMPTY: in_fire -> FULL (main <= input).
  FULL: in_fire & out_fire -> FULL (main <= input). in_fire & !out_fire -> SKID (skid <= input). !in_fire & out_fire -> EMPTY. Neither -> hold.
  SKID: if_ready=0. out_fire -> FULL (main <= skid). Otherwise hold. in_fire is impossible here.
- Order is preserved. No entry is dropped or duplicated except by flush.
- Flush: highest priority below rst. Next state EMPTY and skid cleared. A simultaneous in_fire entry is discarded. A simultaneous out_fire completes normally, because ID already sampled it.
- Empty payload: whenever id_valid=0, id_pc, id_inst and id_exc read 0, so ID sees NOP (sll $0,$0,0) as in the previous generation.
- stall_cnt increments when id_valid & !id_ready, saturates at all-ones, and is not cleared by flush. Only rst clears it.
- if_ready, id_valid and the payload are all flop outputs. There is no combinational path from id_ready to if_ready.
- Changing if_* while if_valid=1 and if_ready=0 is legal. The stage does not sample in that case.

Decomposition:
- Shared package/defines: ZeroWord, address/data bus widths, exception-code constants (EXC_NONE=0, EXC_ADEL fetch), and the state encoding EMPTY=2'b00, FULL=2'b01, SKID=2'b10.
- One natural sub-module: sat_counter (parametrised CNT_W, inc/clr, saturating), reusable for other performance counters.

Test Plan:
- Reset then stream: rst 2 cycles; drive pc 0xBFC00000..0xBFC0000C, inst 0x24010001.., id_ready=1 -> id_valid rises 1 cycle after each in_fire; PCs appear in order; if_ready stays 1.
- Backpressure: id_ready=0 while feeding 0x100 and 0x104 -> state SKID, if_ready=0, id_pc holds 0x100; then id_ready=1 -> 0x100 then 0x104 delivered, if_ready returns to 1; stall_cnt equals the number of id_ready=0 cycles with id_valid=1.
- Flush with simultaneous input: in SKID, assert flush with if_valid=1 (pc 0x200) -> next cycle id_valid=0, id_pc/id_inst=0, if_ready=1; 0x200 is never seen at ID.
- Exception pass-through: if_exc=4'h4 with pc 0x3 -> id_exc=4'h4 and id_pc=0x3 when delivered; following entry has id_exc=0.
- Counter saturation with CNT_W=3: hold id_valid=1, id_ready=0 for 10 cycles -> stall_cnt=7 and stays 7; flush leaves it 7; rst clears it to 0.
- Mid-operation reset: in SKID, assert rst -> next cycle id_valid=0, all payloads 0, if_ready=1, stall_cnt=0.
